// File: rtl/id_stage_sb.sv
// id_stage_sb: decode stage with bypassed register file, hazard scoreboard and valid/ready output register
module id_stage_sb #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   dec_rs_read,
  input  logic                   dec_rt_read,
  input  logic                   dec_reg_wen,
  input  logic                   dec_write_rd,
  input  logic [CTRL_W-1:0]      dec_ctrl,
  input  logic                   flush,
  input  logic                   reg_wen_WB,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  output logic [ADDR_W-1:0]      dest,
  output logic                   reg_wen,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] pend, clr, eff_pend, set_v, sq;
  logic [ADDR_W-1:0]   rs, rt, rd, dst;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic                wr, hazard, issue, unused_instr;

  assign rs           = instr[21 +: ADDR_W];
  assign rt           = instr[16 +: ADDR_W];
  assign rd           = instr[11 +: ADDR_W];
  assign unused_instr = ^instr;
  assign dst          = dec_write_rd ? rd : rt;
  assign wr           = dec_reg_wen & (dst != '0);

  // same-cycle WB data wins over the stored value so a consumer can issue in the producer's WB cycle
  assign rs_val = rs == '0 ? '0 : (reg_wen_WB && waddr == rs) ? wdata : rf[rs];
  assign rt_val = rt == '0 ? '0 : (reg_wen_WB && waddr == rt) ? wdata : rf[rt];

  assign clr      = reg_wen_WB ? NUM_REGS'(1) << waddr : '0;
  assign eff_pend = pend & ~clr;
  assign hazard   = in_valid & ((dec_rs_read & eff_pend[rs]) | (dec_rt_read & eff_pend[rt]) | (wr & eff_pend[dst]));
  assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush;
  assign issue    = in_valid & in_ready;
  assign set_v    = (issue & wr) ? NUM_REGS'(1) << dst : '0;
  // a writer squashed in the output register will never reach WB, so it must release its bit
  assign sq       = (flush & out_valid & reg_wen) ? NUM_REGS'(1) << dest : '0;

  // register file; register 0 is never written
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    else if (reg_wen_WB && waddr != '0) rf[waddr] <= wdata;
  end

  // scoreboard: a new writer's set overrides a same-cycle clear of that register
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else pend <= ((pend & ~clr & ~sq) | set_v) & ~NUM_REGS'(1);
  end

  // output stage towards EX
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rs_data   <= '0;
      rt_data   <= '0;
      dest      <= '0;
      reg_wen   <= 1'b0;
      ctrl_out  <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      rs_data   <= rs_val;
      rt_data   <= rt_val;
      dest      <= dst;
      reg_wen   <= wr;
      ctrl_out  <= dec_ctrl;
    end else if (flush || out_ready) out_valid <= 1'b0;
  end

  // saturating count of cycles lost to hazards
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (hazard && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end
endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
Parametrised instruction-decode stage for the pipeline. It holds the register file with write-before-read bypass. A per-register scoreboard detects RAW and WAW hazards against in-flight writers and stalls the front end. Decoded operands and control are registered into a valid/ready output stage feeding EX. It sits between IF (valid/ready) and EX, and takes its write-back port from WB.

Parameters:
DATA_W, 32, register/operand width
NUM_REGS, 32, number of architectural registers; register 0 hardwired to zero
ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
CTRL_W, 16, width of opaque decoder control bundle passed to EX
STALL_CNT_W, 16, width of saturating hazard-stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF presents instruction
in_ready  out  1  ID accepts instruction this cycle
instr  in  32  instruction; rs=[25:21], rt=[20:16], rd=[15:11] (low ADDR_W bits used)
dec_rs_read  in  1  instruction reads rs
dec_rt_read  in  1  instruction reads rt
dec_reg_wen  in  1  instruction writes a register
dec_write_rd  in  1  destination is rd (else rt)
dec_ctrl  in  CTRL_W  control bundle, passed through
flush  in  1  squash ID input and output register (branch/jump taken in EX)
reg_wen_WB  in  1  WB write enable
waddr  in  ADDR_W  WB write address
wdata  in  DATA_W  WB write data
out_valid  out  1  EX-side payload valid
out_ready  in  1  EX accepts payload
rs_data  out  DATA_W  registered rs operand
rt_data  out  DATA_W  registered rt operand
dest  out  ADDR_W  registered destination index
reg_wen  out  1  registered write enable (0 if dest==0)
ctrl_out  out  CTRL_W  registered dec_ctrl
stall_cnt  out  STALL_CNT_W  hazard-stall cycle count

Behaviour:
- Reset: all registers, scoreboard, out_valid, rs_data, rt_data, dest, reg_wen, ctrl_out and stall_cnt cleared to 0. in_ready is combinational; with reset applied it evaluates to 1.
- Register file: write at the clk edge when reg_wen_WB and waddr!=0. Writes to register 0 are ignored. Register 0 always reads 0.
- Read bypass: if reg_wen_WB, waddr!=0 and waddr equals the source index, the read returns wdata in the same cycle.
- Destination: dst = dec_write_rd ? rd : rt. wr = dec_reg_wen & (dst!=0).
- Scoreboard: one pending bit per register; bit 0 is never set.
  - clr[i] = reg_wen_WB & waddr==i.
  - eff_pend[i] = pend[i] & ~clr[i].
- Hazard (combinational):
  - (dec_rs_read & eff_pend[rs]) | (dec_rt_read & eff_pend[rt]) | (wr & eff_pend[dst]).
  - Only evaluated when in_valid.
- in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
- issue = in_valid & in_ready.
- On issue, the output register loads the operands, dst, wr and dec_ctrl, and sets out_valid=1. pend[dst] is set if wr.
- If out_valid & out_ready & ~issue, out_valid drops to 0. Otherwise payload and out_valid are held (no change while out_valid & ~out_ready).
- Pending-bit update per cycle:
  - pend_next = (pend & ~clr & ~sq) | set.
  - Set has priority over clear on the same index.
  - sq[i] = flush & out_valid & reg_wen & dest==i (squashed writer releases its bit).
- Flush: out_valid<=0 next cycle and no issue this cycle. The IF instruction is not consumed; IF refetches. WB writes in the same cycle still complete.
- stall_cnt increments by 1 each cycle with in_valid & hazard & ~flush. It saturates at all-ones and does not wrap.
- Latency: 1 cycle from issue to out_valid.
- Back-to-back dependent instructions stall until the producer's WB cycle. The consumer issues in the WB cycle via the bypass.
- Reset mid-operation clears the scoreboard and output register; in-flight WB writes in that cycle are dropped.

Test Plan:
1. Reset, then issue add with rs=1, rt=2 after WB wrote r1=5, r2=7 -> next cycle out_valid=1, rs_data=5, rt_data=7, stall_cnt=0.
2. Issue writer of r3, then reader of r3 -> in_ready=0 until WB cycle with waddr=3, wdata=0xAA. Reader then issues that cycle with rs_data=0xAA and pend[3] cleared. stall_cnt equals the number of stalled cycles.
3. Write to r0 via WB (wdata=0xFFFF) and an instruction with dst=0 -> r0 still reads 0, reg_wen=0, and no stall occurs for a later r0 reader.
4. out_ready=0 for 3 cycles with out_valid=1 -> payload stable and in_ready=0. With out_ready=1, the next instruction issues the same cycle.
5. flush while the output register holds a writer of r4 -> out_valid=0 next cycle, pend[4]=0, and a subsequent r4 reader issues without stall.
6. Force 2^STALL_CNT_W+5 hazard cycles (small STALL_CNT_W=4) -> stall_cnt holds at 15.
